// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared encodings for the multi-cycle 16-bit-instruction MIPS core
package mips_mc_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLTI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_SLT = 4'd4;
  localparam logic [3:0] F_JR  = 4'd8;

  localparam logic [2:0] LINK_REG = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

endpackage

// File: rtl/mips_mc_regfile.sv
// rtl/mips_mc_regfile.sv - NREGS x XLEN register file, two async reads, one sync write
// r0 is never written and always reads as zero.
module mips_mc_regfile #(
  parameter int XLEN  = 16,
  parameter int NREGS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [2:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [2:0]      raddr1_i,
  input  logic [2:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 3'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 3'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 3'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multi-cycle MIPS core on a single shared valid/ready memory bus
// FSM, ALU and PC logic live here; the register file is a sub-module.
import mips_mc_pkg::*;

module mips_multicycle #(
  parameter int              XLEN     = 16,
  parameter int              NREGS    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] alu_result,
  output logic            retire,
  output logic            illegal
);

  state_t          state_q;
  logic [15:0]     ir_q;
  logic [XLEN-1:0] pc_q, a_q, b_q, alu_q, mdr_q;
  logic            mem_req_q, mem_we_q, retire_q, illegal_q;

  logic [2:0]      op, rs, rt, rd;
  logic [3:0]      funct;
  logic [XLEN-1:0] simm, jump_tgt, pc_plus2;
  logic            is_r, is_jr, is_illegal, ends_in_exec;

  assign op       = ir_q[15:13];
  assign rs       = ir_q[12:10];
  assign rt       = ir_q[9:7];
  assign rd       = ir_q[6:4];
  assign funct    = ir_q[3:0];
  assign simm     = {{(XLEN-7){ir_q[6]}}, ir_q[6:0]};
  assign jump_tgt = {pc_q[XLEN-1:14], ir_q[12:0], 1'b0};
  assign pc_plus2 = pc_q + {{(XLEN-2){1'b0}}, 2'd2};

  assign is_r       = (op == OP_R);
  assign is_jr      = is_r && (funct == F_JR);
  assign is_illegal = is_r && !is_jr && (funct > F_SLT);
  // These finish in EXEC: no register write-back and no data transfer.
  assign ends_in_exec = is_jr || is_illegal || (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ);

  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_b, alu_out;

  always_comb begin
    alu_b  = (is_r || op == OP_BEQ) ? b_q : simm;
    alu_op = ALU_ADD;
    if (is_r) begin
      case (funct)
        F_SUB:   alu_op = ALU_SUB;
        F_AND:   alu_op = ALU_AND;
        F_OR:    alu_op = ALU_OR;
        F_SLT:   alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (op == OP_SLTI) begin
      alu_op = ALU_SLT;
    end else if (op == OP_BEQ) begin
      alu_op = ALU_SUB;
    end
    case (alu_op)
      ALU_SUB: alu_out = a_q - alu_b;
      ALU_AND: alu_out = a_q & alu_b;
      ALU_OR:  alu_out = a_q | alu_b;
      ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
      default: alu_out = a_q + alu_b;
    endcase
  end

  logic            rf_we;
  logic [2:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata, rf_rdata1, rf_rdata2;

  // jal links in EXEC; every other write happens in WB, so one port suffices.
  assign rf_we    = (state_q == S_WB) || (state_q == S_EXEC && op == OP_JAL);
  assign rf_waddr = (state_q == S_EXEC) ? LINK_REG : (is_r ? rd : rt);
  assign rf_wdata = (state_q == S_EXEC) ? pc_q : ((op == OP_LW) ? mdr_q : alu_q);

  mips_mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        // Entering FETCH with the request low (after reset or a store) costs one idle cycle.
        S_FETCH: begin
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ready) begin
            ir_q      <= mem_rdata[15:0];
            pc_q      <= pc_plus2;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q       <= rf_rdata1;
          b_q       <= rf_rdata2;
          retire_q  <= ends_in_exec;
          illegal_q <= is_illegal;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          alu_q     <= alu_out;
          state_q   <= S_FETCH;
          mem_req_q <= 1'b1;
          if (op == OP_LW || op == OP_SW) begin
            state_q  <= S_MEM;
            mem_we_q <= (op == OP_SW);
          end else if (!ends_in_exec) begin
            state_q   <= S_WB;
            mem_req_q <= 1'b0;
            retire_q  <= 1'b1;
          end
          if (is_jr) begin
            pc_q <= {a_q[XLEN-1:1], 1'b0};
          end else if (op == OP_J || op == OP_JAL) begin
            pc_q <= jump_tgt;
          end else if (op == OP_BEQ && a_q == b_q) begin
            pc_q <= pc_q + (simm << 1);
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (mem_we_q) begin
              state_q <= S_FETCH;
            end else begin
              mdr_q    <= mem_rdata;
              retire_q <= 1'b1;
              state_q  <= S_WB;
            end
          end
        end
        S_WB: begin
          mem_req_q <= 1'b1;
          state_q   <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_wdata  = b_q;
  assign pc_out     = pc_q;
  assign alu_result = alu_q;
  // A store completes in whichever MEM cycle sees ready, so that retire term is combinational.
  assign retire     = retire_q || (state_q == S_MEM && mem_req_q && mem_we_q && mem_ready);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - scoreboard bench: expected bus transfers queued, monitor compares
module tb_mips_multicycle;

  localparam logic [2:0] R = 3'b000, SLTI = 3'b001, J = 3'b010, JAL = 3'b011;
  localparam logic [2:0] LW = 3'b100, SW = 3'b101, BEQ = 3'b110, ADDI = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready, retire, illegal;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out, alu_result;

  mips_multicycle #(.XLEN(16), .NREGS(8), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc_out     (pc_out),
    .alu_result (alu_result),
    .retire     (retire),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:1023];
  int waits = 0;
  int wait_cnt = 0;

  // ready may be high while no request is pending; the core must ignore it
  assign mem_rdata = mem[mem_addr[9:0]];
  assign mem_ready = (wait_cnt >= waits);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 0;
    end else if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
      wait_cnt <= 0;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } xact_t;

  xact_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic exp_f(input logic [15:0] a);
    exp_q.push_back('{1'b0, a, 16'h0});
  endtask
  task automatic exp_r(input logic [15:0] a);
    exp_q.push_back('{1'b0, a, 16'h0});
  endtask
  task automatic exp_w(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back('{1'b1, a, d});
  endtask

  function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int f);
    return {R, 3'(rs), 3'(rt), 3'(rd), 4'(f)};
  endfunction
  function automatic logic [15:0] enc_i(input logic [2:0] op, input int rs, input int rt, input int imm);
    return {op, 3'(rs), 3'(rt), 7'(imm)};
  endfunction
  function automatic logic [15:0] enc_j(input logic [2:0] op, input int tgt);
    return {op, 13'(tgt)};
  endfunction

  always @(negedge clk) begin
    if (reset && mem_req && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("bus_unexpected", {mem_we, mem_addr, mem_wdata}, 33'h0);
      end else begin
        xact_t e;
        e = exp_q.pop_front();
        chk("bus_xact", {mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0)}, {e.we, e.addr, e.data});
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
  endtask

  task automatic wait_empty(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      chk(name, 33'(exp_q.size()), 33'h0);
      exp_q.delete();
    end
  endtask

  int n, rcount, ill, start, lw_end, b2b, hit;
  logic prev_done;

  initial begin
    // Phase 1: zero wait states, ALU ops, illegal, r0, jumps/branches, load/store
    reset = 1'b0;
    waits = 0;
    clear_mem();
    mem[16'h000] = enc_i(ADDI, 0, 1, 5);
    mem[16'h002] = enc_i(ADDI, 0, 2, -1);
    mem[16'h004] = enc_r(1, 2, 3, 0);
    mem[16'h006] = enc_i(SW, 0, 3, 7);
    mem[16'h008] = enc_r(1, 1, 1, 15);
    mem[16'h00A] = enc_i(ADDI, 0, 0, 7);
    mem[16'h00C] = enc_j(J, 16'h008);
    mem[16'h00E] = enc_j(J, 16'h100);
    mem[16'h010] = enc_i(BEQ, 1, 1, -2);
    mem[16'h200] = enc_j(JAL, 16'h110);
    mem[16'h220] = enc_i(SW, 0, 0, 5);
    mem[16'h222] = enc_i(SW, 0, 7, 11);
    mem[16'h224] = enc_i(SW, 0, 1, 9);
    mem[16'h226] = enc_i(LW, 0, 4, 7);
    mem[16'h228] = enc_i(SW, 0, 4, 13);
    mem[16'h22A] = enc_i(SLTI, 2, 5, 0);
    mem[16'h22C] = enc_i(SW, 0, 5, 15);
    mem[16'h22E] = enc_j(J, 16'h117);
    exp_f(16'h000); exp_f(16'h002); exp_f(16'h004);
    exp_f(16'h006); exp_w(16'h0007, 16'h0004);
    exp_f(16'h008); exp_f(16'h00A); exp_f(16'h00C);
    exp_f(16'h010); exp_f(16'h00E); exp_f(16'h200);
    exp_f(16'h220); exp_w(16'h0005, 16'h0000);
    exp_f(16'h222); exp_w(16'h000B, 16'h0202);
    exp_f(16'h224); exp_w(16'h0009, 16'h0005);
    exp_f(16'h226); exp_r(16'h0007);
    exp_f(16'h228); exp_w(16'h000D, 16'h0004);
    exp_f(16'h22A);
    exp_f(16'h22C); exp_w(16'h000F, 16'h0001);
    exp_f(16'h22E);
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 33'(mem_req), 33'h0);
    chk("rst_mem_we", 33'(mem_we), 33'h0);
    chk("rst_pc", 33'(pc_out), 33'h0);
    chk("rst_alu", 33'(alu_result), 33'h0);
    chk("rst_retire_illegal", 33'({retire, illegal}), 33'h0);
    reset = 1'b1;
    n = 0; rcount = 0; ill = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (retire) begin
        rcount++;
        if (rcount == 1) begin
          chk("addi_retire_cycle", 33'(n), 33'd4);
          chk("addi_pc", 33'(pc_out), 33'h2);
        end
        if (rcount == 3) chk("add_alu_result", 33'(alu_result), 33'h0004);
      end
      if (illegal) ill++;
    end
    wait_empty("p1_timeout", 1);
    chk("illegal_pulses", 33'(ill), 33'd1);
    chk("p1_retire_count", 33'(rcount), 33'd17);

    // Phase 2: two wait states per transfer, store/load timing and jr
    reset = 1'b0;
    waits = 2;
    clear_mem();
    mem[16'h000] = enc_i(ADDI, 0, 1, 5);
    mem[16'h002] = enc_i(SW, 0, 1, 3);
    mem[16'h004] = enc_i(LW, 0, 4, 3);
    mem[16'h006] = enc_i(SW, 0, 4, 1);
    mem[16'h008] = enc_i(ADDI, 0, 6, 16'h30);
    mem[16'h00A] = enc_r(6, 0, 0, 8);
    mem[16'h030] = enc_j(J, 16'h018);
    exp_f(16'h000);
    exp_f(16'h002); exp_w(16'h0003, 16'h0005);
    exp_f(16'h004); exp_r(16'h0003);
    exp_f(16'h006); exp_w(16'h0001, 16'h0005);
    exp_f(16'h008); exp_f(16'h00A); exp_f(16'h030);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0; start = -1; lw_end = -1; b2b = 0; prev_done = 1'b0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (prev_done && mem_req) b2b++;
      prev_done = mem_req && mem_ready;
      if (start < 0 && mem_req && !mem_we && mem_addr == 16'h0004) start = n;
      else if (start >= 0 && lw_end < 0 && retire) lw_end = n;
    end
    wait_empty("p2_timeout", 1);
    chk("lw_cycles", 33'(lw_end - start + 1), 33'd9);
    chk("back_to_back_req", 33'(b2b), 33'd0);

    // Phase 3: reset asserted while a load is stalled in MEM
    reset = 1'b0;
    waits = 4;
    clear_mem();
    mem[16'h000] = enc_i(LW, 0, 1, 1);
    exp_f(16'h000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hit = 0;
    for (int i = 0; i < 60 && hit == 0; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_addr == 16'h0001) hit = 1;
    end
    chk("reached_mem", 33'(hit), 33'd1);
    chk("mem_alu_addr", 33'(alu_result), 33'h1);
    #2 reset = 1'b0;
    #1;
    chk("midmem_req_drop", 33'(mem_req), 33'h0);
    chk("midmem_pc", 33'(pc_out), 33'h0);
    chk("midmem_alu", 33'(alu_result), 33'h0);
    exp_f(16'h000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_req_after_reset", 33'({mem_req, mem_addr}), {16'h0, 1'b1, 16'h0000});
    wait_empty("p3_timeout", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
